// File: rtl/serial_hikizan.sv
// Bit-serial WIDTH-bit subtractor (d = a - b), one bit per clock, start/busy/done handshake.
// Optional signed-overflow flag enabled by defining SERIAL_HIKIZAN_OVF_EN.
//
// state  | meaning
// IDLE   | waiting for start; outputs hold last result
// RUN    | one bit per cycle, LSB first, WIDTH cycles
// DONE   | d/bout valid, done pulses; start here chains the next operation
module serial_hikizan #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bout
`ifdef SERIAL_HIKIZAN_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state_q, state_n;

  // The minuend register doubles as the result register: as operand bits
  // shift out of the LSB, difference bits shift into the vacated MSB.
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic             brw_q;
  logic [CW-1:0]    cnt_q;

  logic ai, bi, di, brw_nx, last;
  logic load, step;

  assign ai     = a_sr[0];
  assign bi     = b_sr[0];
  assign di     = ai ^ bi ^ brw_q;
  assign brw_nx = (~ai & bi) | (~(ai ^ bi) & brw_q);
  assign last   = (cnt_q == CW'(WIDTH - 1));

`ifdef SERIAL_HIKIZAN_OVF_EN
  logic a_msb, b_msb;
`endif

  always_comb begin
    state_n = state_q;
    load    = 1'b0;
    step    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_n = S_RUN;
        end
      end
      S_RUN: begin
        step = 1'b1;
        if (last) state_n = S_DONE;
      end
      S_DONE: begin
        if (start) begin
          load    = 1'b1;
          state_n = S_RUN;
        end else begin
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_sr    <= '0;
      b_sr    <= '0;
      brw_q   <= 1'b0;
      cnt_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      d       <= '0;
      bout    <= 1'b0;
`ifdef SERIAL_HIKIZAN_OVF_EN
      a_msb   <= 1'b0;
      b_msb   <= 1'b0;
      ovf     <= 1'b0;
`endif
    end else begin
      state_q <= state_n;
      busy    <= (state_n == S_RUN);
      done    <= (state_q == S_RUN) && last;
      if (load) begin
        a_sr  <= a;
        b_sr  <= b;
        brw_q <= 1'b0;
        cnt_q <= '0;
`ifdef SERIAL_HIKIZAN_OVF_EN
        a_msb <= a[WIDTH-1];
        b_msb <= b[WIDTH-1];
`endif
      end else if (step) begin
        a_sr  <= {di, a_sr[WIDTH-1:1]};
        b_sr  <= {1'b0, b_sr[WIDTH-1:1]};
        brw_q <= brw_nx;
        cnt_q <= cnt_q + CW'(1);
        if (last) begin
          // Final bit is folded in directly so the result lands on DONE entry.
          d    <= {di, a_sr[WIDTH-1:1]};
          bout <= brw_nx;
`ifdef SERIAL_HIKIZAN_OVF_EN
          ovf  <= (a_msb ^ b_msb) & (di ^ a_msb);
`endif
        end
      end
    end
  end

endmodule

// File: doc/serial_hikizan.md
# serial_hikizan

Bit-serial N-bit subtractor: the counterpart of the combinational full adder block, computing `d = a - b` one bit per clock through a single full-subtractor cell and a registered borrow. It is the next sequential exercise in the training set and shares its stimulus style with the full adder test. It uses a start/busy/done handshake so a testbench or a later controller can drive it.

## Interface
- `WIDTH`, default 8: operand and result width in bits; legal range 2..32.
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: request a subtraction; sampled only in IDLE or DONE.
- `a` input WIDTH: minuend, captured on the accepted `start`.
- `b` input WIDTH: subtrahend, captured on the accepted `start`.
- `busy` output 1: high while bits are being processed.
- `done` output 1: one-cycle pulse when `d`/`bout` become valid.
- `d` output WIDTH: difference `a - b` modulo 2^WIDTH.
- `bout` output 1: final borrow; 1 when unsigned `a < b`.
- `ovf` output 1: signed overflow; present only with `SERIAL_HIKIZAN_OVF_EN` (see Configuration).

## Operation
- Reset values: state IDLE; `busy`=0, `done`=0, `d`=0, `bout`=0, `ovf`=0.
- The internal borrow, bit counter and shift registers are also cleared on reset.
- States:
  - IDLE: `start`=1 latches `a` and `b` into shift registers, clears the borrow and the counter, then moves to RUN.
  - RUN: each cycle processes bit i (LSB first) and then moves to DONE after WIDTH cycles.
    - `di = ai ^ bi ^ brw`.
    - `brw_next = (~ai & bi) | (~(ai ^ bi) & brw)`.
    - Operand registers shift right; `di` shifts into the MSB of the result register.
  - DONE: on entry, `d` and `bout` are loaded from the result register and the final borrow, and `done`=1 for this cycle only. If `start`=1, new operands are captured and the next state is RUN (back-to-back operation). Otherwise the next state is IDLE.
- `start` is ignored while in RUN. Operands are not re-sampled, and `a`/`b` may change freely during RUN.
- `d`, `bout` and `ovf` hold their last result until the next DONE or reset. They are not cleared by a new `start`.
- Arithmetic is unsigned modulo 2^WIDTH. The counter is sized to reach WIDTH.
- Reset asserted mid-RUN aborts the operation: state goes to IDLE and all outputs go to their reset values on that edge, with no `done` pulse.

## Timing
- Edge 0: `start` is sampled high in IDLE. `busy`=1 from the following cycle.
- `busy` stays high for exactly WIDTH cycles, during edges 1..WIDTH.
- `done`=1 and `d`/`bout` are valid in cycle WIDTH+1, and `busy`=0 in that cycle.
- Total latency from `start` to `done`: WIDTH+1 cycles.
- Back-to-back: a `start` in the DONE cycle gives `busy`=1 in the next cycle. Throughput is one result per WIDTH+1 cycles.
- When `start` and `rst` are high on the same edge, `rst` wins.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- Macro: `SERIAL_HIKIZAN_OVF_EN`.
- When defined:
  - Port `ovf` exists.
  - At DONE, `ovf = (a[MSB] != b[MSB]) && (d[MSB] != a[MSB])`, computed on the captured operands.
  - `ovf` is held with `d` and resets to 0.
- When undefined:
  - Port `ovf` and its logic are absent.
  - All other behaviour is identical.

## Test plan
All cases use WIDTH=8.
- Basic subtraction: `a`=5, `b`=3, `start` pulse → `done` at cycle 9, `d`=0x02, `bout`=0, `busy` high for exactly 8 cycles.
- Borrow out: `a`=3, `b`=5 → `d`=0xFE, `bout`=1. With `a`=0, `b`=0 → `d`=0x00, `bout`=0.
- Overflow (macro defined): `a`=0x80, `b`=0x01 → `d`=0x7F, `bout`=0, `ovf`=1. Then `a`=0x10, `b`=0x01 → `ovf`=0.
- `start` ignored while busy:
  - `a`=0x40, `b`=0x01 started.
  - At cycle 4, `start`=1 with `a`=0xFF, `b`=0xFF.
  - Expect a single `done`, with `d`=0x3F.
  - `d` holds at 0x3F afterwards.
- Back-to-back:
  - `start` held high with `a`=9, `b`=4, then `a`=4, `b`=9 presented during the DONE cycle.
  - Expect `done` at cycles 9 and 18.
  - Results: `d`=0x05/`bout`=0, then `d`=0xFB/`bout`=1.
- Reset mid-operation: `rst` pulsed at cycle 5 of RUN → no `done`, all outputs 0. A following `a`=7, `b`=2 run yields `d`=0x05 after 9 cycles.
